sync_frame_serializer: RTL and testbench

Serial frame transmitter that drives the single-bit line consumed by the team's 1101 pattern detector. It accepts a parallel payload word through a valid/ready handshake and emits a sync preamble (default 1101), then the payload MSB-first, then a forced-low guard gap. The guard gap returns the downstream detector to IDLE before the next frame starts.

---
 rtl/sync_frame_serializer.sv | 122 ++++++++++++
 tb/tb_sync_frame_serializer.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sync_frame_serializer.sv
// Serial frame transmitter: sync preamble, then payload MSB-first, then a forced-low guard gap.
// One word is accepted per frame through a valid/ready handshake; every output is registered.

`timescale 1ns/1ps

module sync_frame_serializer #(
  parameter int unsigned                  SYNC_WIDTH = 4,
  parameter logic        [SYNC_WIDTH-1:0] SYNC_WORD  = 4'b1101,
  parameter int unsigned                  DATA_WIDTH = 4,
  parameter int unsigned                  GAP_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_ready,
  output logic                  data_out,
  output logic                  busy,
  output logic                  tx_done
);

  localparam int unsigned FrameW = SYNC_WIDTH + DATA_WIDTH;
  localparam int unsigned MaxSd  = (SYNC_WIDTH > DATA_WIDTH) ? SYNC_WIDTH : DATA_WIDTH;
  localparam int unsigned MaxCnt = (MaxSd > GAP_CYCLES) ? MaxSd : GAP_CYCLES;
  localparam int unsigned CntW   = $clog2(MaxCnt + 1);

  // Counter holds the number of cycles left in the current state after this one.
  localparam logic [CntW-1:0] SyncLoad = CntW'(SYNC_WIDTH - 1);
  localparam logic [CntW-1:0] DataLoad = CntW'(DATA_WIDTH - 1);
  localparam logic [CntW-1:0] GapLoad  = CntW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {StIdle, StSync, StData, StGap} state_e;

  state_e            state_q;
  logic [FrameW-1:0] frame_q;   // preamble and payload concatenated, shifted out MSB-first
  logic [CntW-1:0]   cnt_q;
  logic              data_out_q;
  logic              tx_ready_q;
  logic              busy_q;
  logic              tx_done_q;

  // Frame sequencer with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      frame_q    <= '0;
      cnt_q      <= '0;
      data_out_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          data_out_q <= 1'b0;
          tx_ready_q <= 1'b1;
          busy_q     <= 1'b0;
          if (tx_valid && tx_ready_q) begin
            // First preamble bit goes out on the acceptance edge itself.
            state_q    <= StSync;
            frame_q    <= {SYNC_WORD, tx_data} << 1;
            data_out_q <= SYNC_WORD[SYNC_WIDTH-1];
            cnt_q      <= SyncLoad;
            tx_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end
        end
        StSync: begin
          data_out_q <= frame_q[FrameW-1];
          frame_q    <= frame_q << 1;
          if (cnt_q == '0) begin
            state_q <= StData;
            cnt_q   <= DataLoad;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        StData: begin
          if (cnt_q == '0) begin
            data_out_q <= 1'b0;
            tx_done_q  <= 1'b1;
            if (GAP_CYCLES > 0) begin
              state_q <= StGap;
              cnt_q   <= GapLoad;
            end else begin
              state_q    <= StIdle;
              tx_ready_q <= 1'b1;
              busy_q     <= 1'b0;
            end
          end else begin
            data_out_q <= frame_q[FrameW-1];
            frame_q    <= frame_q << 1;
            cnt_q      <= cnt_q - CntW'(1);
          end
        end
        StGap: begin
          data_out_q <= 1'b0;
          if (cnt_q == '0) begin
            state_q    <= StIdle;
            tx_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CntW'(1);
          end
        end
        default: begin
          state_q    <= StIdle;
          data_out_q <= 1'b0;
          tx_ready_q <= 1'b0;
          busy_q     <= 1'b0;
        end
      endcase
    end
  end

  assign tx_ready = tx_ready_q;
  assign data_out = data_out_q;
  assign busy     = busy_q;
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_sync_frame_serializer.sv
// Bench for sync_frame_serializer: default instance plus a GAP_CYCLES=0, DATA_WIDTH=8 instance,
// a cycle-level reference model, and directed frame checks with literal expectations.

`timescale 1ns/1ps

module tb_sync_frame_serializer;

  logic        clk   = 1'b0;
  logic        reset = 1'b1;
  logic        val[2];
  logic [31:0] dat[2];

  logic o0_ready, o0_data, o0_busy, o0_done;
  logic o1_ready, o1_data, o1_busy, o1_done;
  logic q_ready[2], q_data[2], q_busy[2], q_done[2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sync_frame_serializer dut0 (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (val[0]),
    .tx_data  (dat[0][3:0]),
    .tx_ready (o0_ready),
    .data_out (o0_data),
    .busy     (o0_busy),
    .tx_done  (o0_done)
  );

  sync_frame_serializer #(
    .DATA_WIDTH (8),
    .GAP_CYCLES (0)
  ) dut1 (
    .clk      (clk),
    .reset    (reset),
    .tx_valid (val[1]),
    .tx_data  (dat[1][7:0]),
    .tx_ready (o1_ready),
    .data_out (o1_data),
    .busy     (o1_busy),
    .tx_done  (o1_done)
  );

  assign q_ready[0] = o0_ready;
  assign q_data[0]  = o0_data;
  assign q_busy[0]  = o0_busy;
  assign q_done[0]  = o0_done;
  assign q_ready[1] = o1_ready;
  assign q_data[1]  = o1_data;
  assign q_busy[1]  = o1_busy;
  assign q_done[1]  = o1_done;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: frame position relative to the acceptance edge decides every output.
  localparam int SWp = 4;
  int          dwp[2] = '{4, 8};
  int          gpp[2] = '{2, 0};
  logic [7:0]  syncw  = 8'h0D;
  int          tcyc   = 0;
  int          k[2]   = '{0, 0};
  logic [31:0] word[2];
  bit          has[2] = '{0, 0};
  logic        exp_data[2]  = '{0, 0};
  logic        exp_ready[2] = '{0, 0};
  logic        exp_busy[2]  = '{0, 0};
  logic        exp_done[2]  = '{0, 0};

  always @(posedge clk or posedge reset) begin
    bit          acc, h;
    int          kk, rel, fb, total;
    logic [31:0] w;
    logic        bitv;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        has[i]       <= 1'b0;
        exp_data[i]  <= 1'b0;
        exp_ready[i] <= 1'b0;
        exp_busy[i]  <= 1'b0;
        exp_done[i]  <= 1'b0;
      end
    end else begin
      tcyc <= tcyc + 1;
      for (int i = 0; i < 2; i++) begin
        acc   = val[i] && exp_ready[i];
        kk    = acc ? tcyc + 1 : k[i];
        w     = acc ? dat[i] : word[i];
        h     = acc || has[i];
        rel   = tcyc + 1 - kk;
        fb    = SWp + dwp[i];
        total = fb + gpp[i];
        if (h && rel < SWp)     bitv = syncw[SWp-1-rel];
        else if (h && rel < fb) bitv = w[fb-1-rel];
        else                    bitv = 1'b0;
        exp_data[i]  <= bitv;
        exp_busy[i]  <= h && (rel < total);
        exp_ready[i] <= !(h && (rel < total));
        exp_done[i]  <= h && (rel == fb);
        k[i]    <= kk;
        word[i] <= w;
        has[i]  <= h;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("model_data%0d", i), 32'(q_data[i]), 32'(exp_data[i]));
      chk($sformatf("model_ready%0d", i), 32'(q_ready[i]), 32'(exp_ready[i]));
      chk($sformatf("model_busy%0d", i), 32'(q_busy[i]), 32'(exp_busy[i]));
      chk($sformatf("model_done%0d", i), 32'(q_done[i]), 32'(exp_done[i]));
    end
  end

  // Send one word and capture ncyc line bits; capture c is the line after edge k+c.
  task automatic run_frame(input int inst, input logic [31:0] d, input int ncyc, input int chg_at,
                           input logic [31:0] chg_val, output logic [31:0] line,
                           output int dones, output int ready_at);
    int w = 0;
    line     = '0;
    dones    = 0;
    ready_at = -1;
    while (!q_ready[inst] && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (!q_ready[inst]) chk("ready_wait", 32'(q_ready[inst]), 32'd1);
    val[inst] = 1'b1;
    dat[inst] = d;
    @(negedge clk);
    val[inst] = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      if (c == chg_at) dat[inst] = chg_val;
      line  = {line[30:0], q_data[inst]};
      dones = dones + int'(q_done[inst]);
      if (q_ready[inst] && ready_at < 0) ready_at = c;
      @(negedge clk);
    end
  endtask

  // Hold tx_valid high and measure acceptance spacing and the low run before each new frame.
  task automatic b2b(input int inst, input logic [31:0] d, input int nacc, input int period,
                     input int min_low);
    int last = -1;
    int cyc  = 0;
    int got  = 0;
    int zrun = 0;
    val[inst] = 1'b1;
    dat[inst] = d;
    while (got < nacc && cyc < 200) begin
      if (q_data[inst] == 1'b0) zrun++;
      else zrun = 0;
      if (q_ready[inst]) begin
        if (last >= 0) begin
          chk($sformatf("b2b_period%0d", inst), 32'(cyc - last), 32'(period));
          chk($sformatf("b2b_low%0d", inst), 32'(zrun >= min_low), 32'd1);
        end
        last = cyc;
        got++;
      end
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("b2b_count%0d", inst), 32'(got), 32'(nacc));
    val[inst] = 1'b0;
    repeat (16) @(negedge clk);
  endtask

  logic [31:0] line;
  int          dn, ra, hit;

  initial begin
    val = '{1'b0, 1'b0};
    dat = '{32'd0, 32'd0};
    #12;
    for (int i = 0; i < 2; i++) begin
      chk("rst_data", 32'(q_data[i]), 32'd0);
      chk("rst_ready", 32'(q_ready[i]), 32'd0);
      chk("rst_busy", 32'(q_busy[i]), 32'd0);
      chk("rst_done", 32'(q_done[i]), 32'd0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_ready0", 32'(q_ready[0]), 32'd1);
    chk("post_rst_ready1", 32'(q_ready[1]), 32'd1);
    chk("post_rst_busy0", 32'(q_busy[0]), 32'd0);

    run_frame(0, 32'hA, 12, -1, 32'h0, line, dn, ra);
    chk("single_line", line, 32'b1101_1010_0000);
    chk("single_done", 32'(dn), 32'd1);
    chk("single_ready_at", 32'(ra), 32'd10);

    run_frame(0, 32'h3, 12, 2, 32'hC, line, dn, ra);
    chk("midchg_line", line, 32'b1101_0011_0000);

    run_frame(0, 32'hD, 12, -1, 32'h0, line, dn, ra);
    chk("pattern_line", line, 32'b1101_1101_0000);
    // First 1101 on the line must complete with the preamble, at capture 3.
    hit = -1;
    for (int c = 3; c < 12; c++) begin
      if (hit < 0 && line[11-c+:4] == 4'b1101) hit = c;
    end
    chk("pattern_first_hit", 32'(hit), 32'd3);

    b2b(0, 32'hF, 4, 11, 3);
    b2b(1, 32'hFF, 4, 13, 1);

    run_frame(1, 32'hA5, 14, -1, 32'h0, line, dn, ra);
    chk("gap0_line", line, 32'b1101_1010_0101_00);
    chk("gap0_done", 32'(dn), 32'd1);
    chk("gap0_ready_at", 32'(ra), 32'd12);

    // Abort a frame during payload bit 2.
    while (!q_ready[0]) @(negedge clk);
    val[0] = 1'b1;
    dat[0] = 32'hA;
    @(negedge clk);
    val[0] = 1'b0;
    repeat (6) @(negedge clk);
    chk("abort_bit2", 32'(q_data[0]), 32'd1);
    #1 reset = 1'b1;
    #1;
    chk("abort_data", 32'(q_data[0]), 32'd0);
    chk("abort_busy", 32'(q_busy[0]), 32'd0);
    chk("abort_ready", 32'(q_ready[0]), 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready_back", 32'(q_ready[0]), 32'd1);
    dn = 0;
    repeat (12) begin
      dn = dn + int'(q_done[0]);
      @(negedge clk);
    end
    chk("abort_no_done", 32'(dn), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
